fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front-end that drives the program counter's control inputs and consumes its output.
- Issues `pc_in` as the read address to a synchronous instruction memory (1-cycle read latency).
- Buffers returned words with their PC in a small prefetch queue and presents them to decode via a valid/ready handshake.
- Handles the initial start load and datapath branch redirects, flushing stale instructions.

Parameters:
- DEPTH, 4, prefetch queue entries (power of two, ≥2).
- PC_W, 11, PC / instruction-memory address width.
- INSN_W, 32, instruction word width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begin fetching at start_addr.
- start_addr  in  PC_W  boot PC.
- pc_in  in  PC_W  current PC from the PC register.
- load_pc  out  1  PC load enable.
- sel_pc  out  2  PC source select: 00 increment, 01 start_pc, 11 dp_pc.
- start_pc  out  PC_W  value for the sel_pc=01 load.
- dp_pc  out  PC_W  value for the sel_pc=11 load.
- imem_addr  out  PC_W  instruction memory read address.
- imem_rd  out  1  read strobe.
- imem_rdata  in  INSN_W  read data, valid the cycle after imem_rd.
- redirect  in  1  branch taken in datapath.
- redirect_pc  in  PC_W  branch target.
- insn_valid  out  1  queue head valid.
- insn_ready  in  1  decode accepts head.
- insn  out  INSN_W  head instruction.
- insn_pc  out  PC_W  address of head instruction.

Behaviour:
- Reset values:
  - State IDLE.
  - load_pc=0, sel_pc=00, imem_rd=0, insn_valid=0.
  - insn, insn_pc, start_pc and dp_pc are 0.
  - Queue empty; pending=0.
- FSM states:
  - IDLE: no PC loads, no reads. start=1 → START.
  - START (1 cycle): load_pc=1, sel_pc=01, start_pc=start_addr. Next state RUN.
  - RUN: fetch issue active.
  - REDIRECT (1 cycle): entered from RUN when redirect=1 at a clock edge.
    - load_pc=1, sel_pc=11, dp_pc=latched redirect_pc, imem_rd=0. Next state RUN.
- Issue rule in RUN, when count+pending < DEPTH and redirect=0:
  - imem_rd=1, imem_addr=pc_in, load_pc=1, sel_pc=00, so the PC increments at the same edge.
  - pending←1 and rd_pc←pc_in.
- Otherwise in RUN: imem_rd=0, load_pc=0, so the PC holds.
- Return: when pending=1, the next cycle's imem_rdata is enqueued with rd_pc and pending clears. If no new issue that cycle, pending stays cleared.
- Dequeue: the head pops when insn_valid & insn_ready. insn/insn_pc come from the head entry.
- Enqueue and dequeue in the same cycle are both performed; count is unchanged.
- Full: count==DEPTH blocks issue. The credit check guarantees a returning word always has a slot.
- Empty: insn_valid=0. Data written this cycle appears on insn_valid the next cycle; there is no bypass.
- Redirect flush (at the edge where redirect=1 in RUN or REDIRECT):
  - Queue cleared; pending cleared, and the in-flight return is discarded.
  - insn_valid=0 next cycle.
  - The first post-redirect read issues the cycle after REDIRECT, at the target.
- Redirect during START: ignored.
- Redirect in IDLE: ignored.
- Back-to-back redirects: the latest redirect_pc wins; REDIRECT repeats.
- start while not IDLE: ignored.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- PC arithmetic wraps modulo 2^PC_W; this happens in the PC register, and the fetch unit applies no checks.
- Asynchronous reset mid-operation: everything returns immediately to reset values, and any in-flight return is dropped.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds outputs:
  - perf_fetched (32 bits): words enqueued.
  - perf_flushed (32 bits): valid entries plus in-flight reads discarded on redirect.
  - perf_stall (32 bits): RUN cycles with issue blocked by a full queue.
- All three counters are saturating, reset to 0, and are not cleared by redirect.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, start=1 with start_addr=0x010 → START one cycle (sel_pc=01, load_pc=1), then imem_addr=0x010, 0x011, 0x012 on consecutive cycles.
- insn_ready held 1, memory returns word=addr+0x1000 → insn/insn_pc stream 0x1010/0x010, 0x1011/0x011, one per cycle.
- insn_ready=0 from start → exactly 4 entries enqueued, then issue stops and load_pc=0; raising ready drains 0x010..0x013 in order and issue resumes at 0x014.
- Redirect to 0x200 while the queue holds 3 and a read is pending → next cycle insn_valid=0, sel_pc=11, dp_pc=0x200; next fetch addr 0x200; stale words never appear.
- Back-to-back redirects to 0x300 then 0x340 → first fetch at 0x340; with FETCH_PERF_EN, perf_flushed counts every discarded word.
- Assert rst during RUN with queue non-empty → insn_valid, imem_rd and load_pc drop to 0 immediately; a new start at 0x7FF fetches 0x7FF then 0x000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: steers the PC, reads imem and buffers words for decode.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 11,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic [PC_W-1:0]   pc_in,
  output logic              load_pc,
  output logic [1:0]        sel_pc,
  output logic [PC_W-1:0]   start_pc,
  output logic [PC_W-1:0]   dp_pc,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_rd,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn,
  output logic [PC_W-1:0]   insn_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_START = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_REDIR = 2'b11;

  localparam logic [1:0] SEL_INC   = 2'b00;
  localparam logic [1:0] SEL_START = 2'b01;
  localparam logic [1:0] SEL_DP    = 2'b11;

  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              pending_q, pending_d;
  logic [PC_W-1:0]   rd_pc_q, rd_pc_d;
  logic [PC_W-1:0]   start_pc_q, start_pc_d;
  logic [PC_W-1:0]   dp_pc_q, dp_pc_d;

  logic [INSN_W-1:0] data_q [DEPTH];
  logic [PC_W-1:0]   pcs_q  [DEPTH];

  logic [AW+1:0]     credit;
  logic              credit_ok;
  logic              issue;
  logic              flush;
  logic              enq;
  logic              deq;

  // Outstanding reads reserve a slot so a returning word never overflows.
  assign credit    = {1'b0, count_q} + (AW+2)'(pending_q);
  assign credit_ok = credit < DEPTH_C;

  assign flush = redirect & ((state_q == S_RUN) | (state_q == S_REDIR));
  assign enq   = pending_q & ~flush;
  assign deq   = insn_valid & insn_ready;

  assign insn_valid = (count_q != '0);
  assign insn       = insn_valid ? data_q[rd_ptr_q] : '0;
  assign insn_pc    = insn_valid ? pcs_q[rd_ptr_q]  : '0;
  assign imem_addr  = pc_in;
  assign start_pc   = start_pc_q;
  assign dp_pc      = dp_pc_q;

  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    sel_pc  = SEL_INC;
    imem_rd = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        load_pc = 1'b1;
        sel_pc  = SEL_START;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          state_d = S_REDIR;
        end else if (credit_ok) begin
          issue   = 1'b1;
          imem_rd = 1'b1;
          load_pc = 1'b1;
        end
      end
      S_REDIR: begin
        load_pc = 1'b1;
        sel_pc  = SEL_DP;
        if (!redirect) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pending_d  = issue;
    rd_pc_d    = rd_pc_q;
    start_pc_d = start_pc_q;
    dp_pc_d    = dp_pc_q;
    if (issue) rd_pc_d = pc_in;
    if ((state_q == S_IDLE) && start) start_pc_d = start_addr;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pending_d = 1'b0;
      dp_pc_d   = redirect_pc;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      rd_pc_q    <= '0;
      start_pc_q <= '0;
      dp_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      rd_pc_q    <= rd_pc_d;
      start_pc_q <= start_pc_d;
      dp_pc_q    <= dp_pc_d;
    end
  end

  // Queue storage needs no reset: head outputs are gated by insn_valid.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pcs_q[wr_ptr_q]  <= rd_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q, stall_q;
  logic [32:0] fl_sum;

  assign fl_sum = {1'b0, flushed_q} + 33'(count_q) + 33'(pending_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
      stall_q   <= '0;
    end else begin
      if (enq && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
      if (flush) flushed_q <= fl_sum[32] ? '1 : fl_sum[31:0];
      if ((state_q == S_RUN) && !redirect && !credit_ok && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register and 1-cycle imem model.
module tb_fetch_unit;
  localparam int PC_W   = 11;
  localparam int INSN_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [PC_W-1:0]   start_addr = '0;
  logic [PC_W-1:0]   pc_q;
  logic              load_pc;
  logic [1:0]        sel_pc;
  logic [PC_W-1:0]   start_pc;
  logic [PC_W-1:0]   dp_pc;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_rd;
  logic [INSN_W-1:0] imem_rdata = '0;
  logic              redirect = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
  logic              insn_valid;
  logic              insn_ready = 1'b0;
  logic [INSN_W-1:0] insn;
  logic [PC_W-1:0]   insn_pc;

  int n_chk  = 0;
  int n_pass = 0;
  int nrd;

  fetch_unit #(.DEPTH(4), .PC_W(PC_W), .INSN_W(INSN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .pc_in(pc_q), .load_pc(load_pc), .sel_pc(sel_pc),
    .start_pc(start_pc), .dp_pc(dp_pc), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else if (load_pc) begin
      case (sel_pc)
        2'b00:   pc_q <= pc_q + 11'd1;
        2'b01:   pc_q <= start_pc;
        2'b11:   pc_q <= dp_pc;
        default: pc_q <= pc_q;
      endcase
    end
  end

  always @(posedge clk)
    if (imem_rd) imem_rdata <= 32'h1000 + 32'(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [PC_W-1:0] a);
    start      = 1'b1;
    start_addr = a;
    cyc();
    start      = 1'b0;
  endtask

  task automatic pulse_rst();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    smp();
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_rd", 32'(imem_rd), 32'd0);
    chk("rst_load", 32'(load_pc), 32'd0);
    chk("rst_sel", 32'(sel_pc), 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_ipc", 32'(insn_pc), 32'd0);
    chk("rst_spc", 32'(start_pc), 32'd0);
    chk("rst_dpc", 32'(dp_pc), 32'd0);
    cyc();
    rst = 1'b0;
    redirect = 1'b1;
    redirect_pc = 11'h155;
    smp();
    chk("idle_redir_load", 32'(load_pc), 32'd0);
    cyc();
    redirect = 1'b0;
    smp();
    chk("idle_redir_dpc", 32'(dp_pc), 32'd0);

    // Streaming with decode always ready
    cyc();
    insn_ready = 1'b1;
    do_start(11'h010);
    smp();
    chk("st_load", 32'(load_pc), 32'd1);
    chk("st_sel", 32'(sel_pc), 32'd1);
    chk("st_spc", 32'(start_pc), 32'h010);
    chk("st_rd", 32'(imem_rd), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
      chk("s_addr", 32'(imem_addr), 32'h010 + i);
      chk("s_rd", 32'(imem_rd), 32'd1);
      if (i >= 2) begin
        chk("s_valid", 32'(insn_valid), 32'd1);
        chk("s_ipc", 32'(insn_pc), 32'h010 + i - 2);
        chk("s_insn", insn, 32'h1010 + i - 2);
      end else begin
        chk("s_valid0", 32'(insn_valid), 32'd0);
      end
    end

    // Back-pressure fills the queue
    pulse_rst();
    insn_ready = 1'b0;
    do_start(11'h010);
    nrd = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      smp();
      if (imem_rd) nrd++;
    end
    chk("full_reads", 32'(nrd), 32'd4);
    chk("full_load", 32'(load_pc), 32'd0);
    chk("full_ipc", 32'(insn_pc), 32'h010);
    cyc();
    insn_ready = 1'b1;
    smp();
    chk("drain_ipc0", 32'(insn_pc), 32'h010);
    chk("drain_rd0", 32'(imem_rd), 32'd0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      smp();
      chk("drain_ipc", 32'(insn_pc), 32'h010 + i);
      chk("drain_insn", insn, 32'h1010 + i);
      if (i == 1) begin
        chk("resume_rd", 32'(imem_rd), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'h014);
      end
    end

    // Redirect with 3 queued and one read in flight
    pulse_rst();
    insn_ready = 1'b0;
    do_start(11'h010);
    repeat (5) cyc();
    redirect = 1'b1;
    redirect_pc = 11'h200;
    smp();
    chk("rd_pre_valid", 32'(insn_valid), 32'd1);
    chk("rd_pre_rd", 32'(imem_rd), 32'd0);
    cyc();
    redirect = 1'b0;
    smp();
    chk("rd_valid", 32'(insn_valid), 32'd0);
    chk("rd_sel", 32'(sel_pc), 32'd3);
    chk("rd_load", 32'(load_pc), 32'd1);
    chk("rd_dpc", 32'(dp_pc), 32'h200);
    chk("rd_rd", 32'(imem_rd), 32'd0);
    cyc();
    insn_ready = 1'b1;
    smp();
    chk("rd_faddr", 32'(imem_addr), 32'h200);
    chk("rd_frd", 32'(imem_rd), 32'd1);
    chk("rd_v1", 32'(insn_valid), 32'd0);
    cyc();
    smp();
    chk("rd_v2", 32'(insn_valid), 32'd0);
    cyc();
    smp();
    chk("rd_v3", 32'(insn_valid), 32'd1);
    chk("rd_ipc", 32'(insn_pc), 32'h200);
    chk("rd_insn", insn, 32'h1200);

    // Back-to-back redirects
    cyc();
    redirect = 1'b1;
    redirect_pc = 11'h300;
    cyc();
    redirect_pc = 11'h340;
    smp();
    chk("bb_sel", 32'(sel_pc), 32'd3);
    chk("bb_dpc0", 32'(dp_pc), 32'h300);
    chk("bb_valid", 32'(insn_valid), 32'd0);
    cyc();
    redirect = 1'b0;
    smp();
    chk("bb_dpc1", 32'(dp_pc), 32'h340);
    chk("bb_sel1", 32'(sel_pc), 32'd3);
    cyc();
    smp();
    chk("bb_faddr", 32'(imem_addr), 32'h340);
    chk("bb_frd", 32'(imem_rd), 32'd1);
    cyc();
    smp();
    chk("bb_v1", 32'(insn_valid), 32'd0);
    cyc();
    smp();
    chk("bb_ipc", 32'(insn_pc), 32'h340);
    chk("bb_insn", insn, 32'h1340);

    // Async reset mid-run, then restart at the top of memory
    insn_ready = 1'b0;
    repeat (3) cyc();
    smp();
    chk("ar_pre_valid", 32'(insn_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(insn_valid), 32'd0);
    chk("ar_rd", 32'(imem_rd), 32'd0);
    chk("ar_load", 32'(load_pc), 32'd0);
    cyc();
    rst = 1'b0;
    insn_ready = 1'b1;
    do_start(11'h7FF);
    cyc();
    smp();
    chk("wr_addr0", 32'(imem_addr), 32'h7FF);
    chk("wr_valid0", 32'(insn_valid), 32'd0);
    cyc();
    smp();
    chk("wr_addr1", 32'(imem_addr), 32'h000);
    chk("wr_rd1", 32'(imem_rd), 32'd1);
    cyc();
    smp();
    chk("wr_ipc", 32'(insn_pc), 32'h7FF);
    chk("wr_insn", insn, 32'h17FF);
    cyc();
    smp();
    chk("wr_ipc1", 32'(insn_pc), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
